// File: rtl/my_data_packer.sv
// Beat-to-group packer: gathers BUM-bit beats into AUM-beat frames and VUM frames
// into one held output group. Optional MY_DATA_PACKER_PARITY_EN adds per-frame parity.
module my_data_packer #(
  parameter int AUM = 80,
  parameter int BUM = 70,
  parameter int VUM = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUM-1:0]           in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AUM-1:0][BUM-1:0]  my_data_ab,
  output logic [AUM-1:0][BUM-1:0]  my_data_abv [VUM],
  output logic                     my_data_v [VUM],
  output logic                     my_data_z
`ifdef MY_DATA_PACKER_PARITY_EN
  ,
  output logic                     my_data_par [VUM]
`endif
);

  localparam int BW = (AUM > 1) ? $clog2(AUM) : 1;
  localparam int EW = (VUM > 1) ? $clog2(VUM) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(AUM - 1);
  localparam logic [EW-1:0] E_LAST = EW'(VUM - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1'b1);
  localparam logic [EW-1:0] E_ONE  = EW'(1'b1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic [BW-1:0]             r_b;
  logic [EW-1:0]             r_e;
  logic [AUM-1:0][BUM-1:0]   r_ab;
  logic [AUM-1:0][BUM-1:0]   r_abv [VUM];
  logic                      r_v [VUM];
  logic                      r_z;
  logic [AUM-1:0][BUM-1:0]   w_frame;
  logic                      w_accept;
  logic                      w_out_hs;
  logic                      w_frame_done;
  logic                      w_group_done;
`ifdef MY_DATA_PACKER_PARITY_EN
  logic                      r_par [VUM];
`endif

  function automatic logic f_even_parity(input logic [AUM*BUM-1:0] frame);
    return ^frame;
  endfunction

  assign w_accept     = in_valid && r_in_ready;
  assign w_out_hs     = r_out_valid && out_ready;
  assign w_frame_done = w_accept && ((r_b == B_LAST) || in_last);
  assign w_group_done = w_frame_done && ((r_e == E_LAST) || in_last);

  // Frame being completed this cycle, including the beat arriving now.
  always_comb begin
    w_frame      = r_abv[r_e];
    w_frame[r_b] = in_data;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_group_done) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (w_out_hs) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State register and registered handshake outputs; in_ready stays low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_FILL);
      r_out_valid <= (w_state_nxt == ST_HOLD);
    end
  end

  // Counters and group storage; the output handshake clears the held group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b  <= '0;
      r_e  <= '0;
      r_ab <= '0;
      r_z  <= 1'b0;
      for (int i = 0; i < VUM; i++) begin
        r_abv[i] <= '0;
        r_v[i]   <= 1'b0;
`ifdef MY_DATA_PACKER_PARITY_EN
        r_par[i] <= 1'b0;
`endif
      end
    end else if (w_out_hs) begin
      r_b  <= '0;
      r_e  <= '0;
      r_ab <= '0;
      r_z  <= 1'b0;
      for (int i = 0; i < VUM; i++) begin
        r_abv[i] <= '0;
        r_v[i]   <= 1'b0;
`ifdef MY_DATA_PACKER_PARITY_EN
        r_par[i] <= 1'b0;
`endif
      end
    end else if (w_accept) begin
      r_abv[r_e][r_b] <= in_data;
      if (w_frame_done) begin
        r_v[r_e] <= 1'b1;
        r_ab     <= w_frame;
`ifdef MY_DATA_PACKER_PARITY_EN
        r_par[r_e] <= f_even_parity(w_frame);
`endif
        if (in_last && (r_b != B_LAST)) begin
          r_z <= 1'b1;
        end
        r_b <= '0;
        // Entry counter parks at zero once the group closes so it never passes VUM-1.
        if (w_group_done) begin
          r_e <= '0;
        end else begin
          r_e <= r_e + E_ONE;
        end
      end else begin
        r_b <= r_b + B_ONE;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign my_data_ab  = r_ab;
  assign my_data_abv = r_abv;
  assign my_data_v   = r_v;
  assign my_data_z   = r_z;
`ifdef MY_DATA_PACKER_PARITY_EN
  assign my_data_par = r_par;
`endif

endmodule

// File: tb/tb_my_data_packer.sv
// Directed self-checking bench for my_data_packer with AUM=4, BUM=8, VUM=2.
// Parity cases run only when MY_DATA_PACKER_PARITY_EN is defined.
module tb_my_data_packer;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][7:0]   ab;
  logic [3:0][7:0]   abv [2];
  logic              v [2];
  logic              z;
`ifdef MY_DATA_PACKER_PARITY_EN
  logic              par [2];
`endif

  int n_chk;
  int n_pass;

  my_data_packer #(.AUM(4), .BUM(8), .VUM(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .my_data_ab (ab),
    .my_data_abv(abv),
    .my_data_v  (v),
    .my_data_z  (z)
`ifdef MY_DATA_PACKER_PARITY_EN
    ,
    .my_data_par(par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic release_group();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_out_valid", {63'd0, out_valid}, 64'd0);
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);
    check("rel_abv0", 64'(abv[0]), 64'd0);
    check("rel_abv1", 64'(abv[1]), 64'd0);
    check("rel_v", {62'd0, v[1], v[0]}, 64'd0);
    check("rel_z", {63'd0, z}, 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset release
    repeat (3) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ab", 64'(ab), 64'd0);
    check("rst_abv0", 64'(abv[0]), 64'd0);
    check("rst_v", {62'd0, v[1], v[0]}, 64'd0);
    check("rst_z", {63'd0, z}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", {63'd0, in_ready}, 64'd0);
    tick();
    check("rel_in_ready_high", {63'd0, in_ready}, 64'd1);

    // Full group of eight beats, no in_last
    for (int i = 0; i < 8; i++) begin
      beat(8'h11 + 8'(i), 1'b0);
      if (i == 3) begin
        check("full_mid_ab", 64'(ab), 64'h14131211);
        check("full_mid_v", {62'd0, v[1], v[0]}, 64'd1);
      end
      if (i < 7) begin
        check("full_out_valid_low", {63'd0, out_valid}, 64'd0);
      end
    end
    check("full_out_valid", {63'd0, out_valid}, 64'd1);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_abv0", 64'(abv[0]), 64'h14131211);
    check("full_abv1", 64'(abv[1]), 64'h18171615);
    check("full_ab", 64'(ab), 64'h18171615);
    check("full_v", {62'd0, v[1], v[0]}, 64'd3);
    check("full_z", {63'd0, z}, 64'd0);
    release_group();

    // Short frame terminated by in_last
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b1);
    check("short_out_valid", {63'd0, out_valid}, 64'd1);
    check("short_abv0", 64'(abv[0]), 64'h0000A2A1);
    check("short_abv1", 64'(abv[1]), 64'd0);
    check("short_ab", 64'(ab), 64'h0000A2A1);
    check("short_v", {62'd0, v[1], v[0]}, 64'd1);
    check("short_z", {63'd0, z}, 64'd1);
    release_group();

    // in_last on the final beat of frame 0 truncates the group without z
    beat(8'h31, 1'b0);
    beat(8'h32, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h34, 1'b1);
    check("bnd_out_valid", {63'd0, out_valid}, 64'd1);
    check("bnd_abv0", 64'(abv[0]), 64'h34333231);
    check("bnd_abv1", 64'(abv[1]), 64'd0);
    check("bnd_v", {62'd0, v[1], v[0]}, 64'd1);
    check("bnd_z", {63'd0, z}, 64'd0);

    // Backpressure in HOLD with in_valid asserted
    held     = 32'h34333231;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    check("bp_abv0", 64'(abv[0]), 64'(held));
    check("bp_abv1", 64'(abv[1]), 64'd0);
    check("bp_ab", 64'(ab), 64'(held));
    check("bp_v", {62'd0, v[1], v[0]}, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    release_group();

    // Asynchronous reset in the middle of a frame
    beat(8'h51, 1'b0);
    beat(8'h52, 1'b0);
    beat(8'h53, 1'b0);
    check("ar_partial_abv0", 64'(abv[0]), 64'h00535251);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_abv0", 64'(abv[0]), 64'd0);
    check("ar_in_ready", {63'd0, in_ready}, 64'd0);
    check("ar_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("ar_in_ready_back", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      beat(8'h61 + 8'(i), 1'b0);
    end
    beat(8'h65, 1'b1);
    check("ar_out_valid_grp", {63'd0, out_valid}, 64'd1);
    check("ar_abv0_new", 64'(abv[0]), 64'h64636261);
    check("ar_abv1_new", 64'(abv[1]), 64'h00000065);
    check("ar_ab_new", 64'(ab), 64'h00000065);
    check("ar_v_new", {62'd0, v[1], v[0]}, 64'd3);
    check("ar_z_new", {63'd0, z}, 64'd1);
    release_group();

`ifdef MY_DATA_PACKER_PARITY_EN
    // Parity: frame 0 holds a single set bit, frame 1 is all zero
    beat(8'h01, 1'b0);
    beat(8'h00, 1'b0);
    beat(8'h00, 1'b0);
    beat(8'h00, 1'b0);
    check("par_mid", {63'd0, par[0]}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      beat(8'h00, 1'b0);
    end
    check("par_out_valid", {63'd0, out_valid}, 64'd1);
    check("par_bits", {62'd0, par[1], par[0]}, 64'd1);
    check("par_v", {62'd0, v[1], v[0]}, 64'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("par_cleared", {62'd0, par[1], par[0]}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
